// File: rtl/rstseq_pkg.sv
// -----------------------------------------------------------------------------
// rstseq_pkg
// Shared definitions for the reset sequencer:
//   state_t              - sequencer FSM states (ASSERT, WAIT, RUN)
//   DEF_* localparams    - default parameter values used by the modules
//   max2()               - helper for sizing the shared cycle counter
// -----------------------------------------------------------------------------
package rstseq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int DEF_NUM_DOMAINS     = 4;
  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES  = 255;
  localparam int DEF_DEBOUNCE_CYCLES = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Turns the asynchronous restart button into a single-clock press pulse.
// The key is brought into the clk domain with a 2-flop synchronizer, then:
//   RSTSEQ_DEBOUNCE_EN defined   : press fires once the synchronized key has
//                                  been high for DEBOUNCE_CYCLES consecutive
//                                  clocks, at most once per high period.
//   RSTSEQ_DEBOUNCE_EN undefined : press fires on every 0->1 transition of the
//                                  synchronized key.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset (clears all flops)
//   key   - raw asynchronous button, active-high
//   press - one-clock qualified press pulse
// -----------------------------------------------------------------------------
module key_conditioner
  import rstseq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

`ifdef RSTSEQ_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Counts consecutive high clocks of the synchronized key and parks at
  // DEBOUNCE_CYCLES so the pulse cannot repeat until the key goes low.
  logic [DB_W-1:0] stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
    end else if (!sync2) begin
      stable <= '0;
    end else if (stable != DB_W'(DEBOUNCE_CYCLES)) begin
      stable <= stable + 1'b1;
    end
  end

  assign press = sync2 && (stable == DB_W'(DEBOUNCE_CYCLES - 1));
`else
  logic sync_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_prev <= 1'b0;
    end else begin
      sync_prev <= sync2;
    end
  end

  assign press = sync2 && !sync_prev;
`endif

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Holds all domain resets for HOLD_CYCLES after a (re)start, then releases the
// domains one at a time in ascending order, waiting for each domain's ready
// flag (or TIMEOUT_CYCLES, flagging a sticky timeout) before moving on.
// A qualified key press restarts the whole sequence from any state.
// Optional build macro: RSTSEQ_DEBOUNCE_EN (debounced key qualification,
// handled inside key_conditioner).
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-high reset
//   key         - asynchronous restart button, active-high
//   dom_ready   - per-domain ready flags
//   dom_rst     - per-domain resets, active-high, registered
//   all_ready   - high only in RUN
//   busy        - high in ASSERT or WAIT
//   timeout_err - sticky per-domain timeout flags, cleared only by rst
// -----------------------------------------------------------------------------
module reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int NUM_DOMAINS     = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key,
  input  logic [NUM_DOMAINS-1:0] dom_ready,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   all_ready,
  output logic                   busy,
  output logic [NUM_DOMAINS-1:0] timeout_err
);

  localparam int CNT_W = $clog2(max2(HOLD_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_DOMAINS);

  logic             press;
  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic             last_idx;
  logic             advance;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_conditioner (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .press(press)
  );

  assign last_idx = (idx == IDX_W'(NUM_DOMAINS - 1));
  // A domain is passed either because it reported ready or its wait expired.
  assign advance  = dom_ready[idx] || (count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_ASSERT;
      idx         <= '0;
      count       <= '0;
      dom_rst     <= '1;
      all_ready   <= 1'b0;
      busy        <= 1'b1;
      timeout_err <= '0;
    end else if (press) begin
      // Restart has priority over every transition, including hold expiry
      // and WAIT advances; timeout flags deliberately survive.
      state     <= ST_ASSERT;
      idx       <= '0;
      count     <= '0;
      dom_rst   <= '1;
      all_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (count == CNT_W'(HOLD_CYCLES - 1)) begin
            dom_rst[0] <= 1'b0;
            idx        <= '0;
            count      <= '0;
            state      <= ST_WAIT;
          end else begin
            count <= count + 1'b1;
          end
        end

        ST_WAIT: begin
          if (advance) begin
            if (!dom_ready[idx]) begin
              timeout_err[idx] <= 1'b1;
            end
            count <= '0;
            if (last_idx) begin
              state     <= ST_RUN;
              dom_rst   <= '0;
              all_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              idx                  <= idx + 1'b1;
              dom_rst[idx + 1'b1]  <= 1'b0;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        ST_RUN: begin
          // Ready drops are ignored here; only a restart leaves RUN.
          dom_rst   <= '0;
          all_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= ST_ASSERT;
          idx       <= '0;
          count     <= '0;
          dom_rst   <= '1;
          all_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Directed checks of reset_sequencer at default parameters (4 domains,
// 16-clock hold, 255-clock timeout, 8-clock debounce), 20 ns clock.
// Expected key latencies follow the RSTSEQ_DEBOUNCE_EN build setting.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       key;
  logic [3:0] dom_ready;
  logic [3:0] dom_rst;
  logic       all_ready;
  logic       busy;
  logic [3:0] timeout_err;

  int errors = 0;
  int checks = 0;

  // Edge (counted from key rise) on which the restart takes effect, and the
  // expected outputs after a 4-clock key pulse seen from RUN.
`ifdef RSTSEQ_DEBOUNCE_EN
  localparam int         KEY_LAT   = 10;
  localparam logic [3:0] SK_RST_E3 = 4'h0;
  localparam logic       SK_AR_E3  = 1'b1;
  localparam logic [3:0] SK_RST_E12 = 4'h0;
`else
  localparam int         KEY_LAT   = 3;
  localparam logic [3:0] SK_RST_E3 = 4'hF;
  localparam logic       SK_AR_E3  = 1'b0;
  localparam logic [3:0] SK_RST_E12 = 4'hF;
`endif

  always #10 clk = ~clk;

  reset_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .dom_ready  (dom_ready),
    .dom_rst    (dom_rst),
    .all_ready  (all_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hold rst across two edges and release it 1 ns after an edge, so the
  // next rising edge is edge 1 of the new sequence.
  task automatic apply_rst;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    key       = 1'b0;
    dom_ready = 4'h0;
    rst       = 1'b1;
    #5;
    checks++;
    if ({dom_rst, all_ready, busy, timeout_err} !== {4'hF, 1'b0, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL reset_async: got rst=%h ar=%b busy=%b te=%h want rst=f ar=0 busy=1 te=0",
               dom_rst, all_ready, busy, timeout_err);
    end
    tick();
    tick();
    checks++;
    if ({dom_rst, all_ready, busy} !== {4'hF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_held: got rst=%h ar=%b busy=%b want rst=f ar=0 busy=1",
               dom_rst, all_ready, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_normal_sequence;
    logic [3:0] exp_rst;
    dom_ready = 4'hF;
    apply_rst();
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_rst = (e < 16) ? 4'hF : (e == 16) ? 4'hE : (e == 17) ? 4'hC :
                (e == 18) ? 4'h8 : 4'h0;
      checks++;
      if ({dom_rst, all_ready, busy} !== {exp_rst, (e >= 20), (e < 20)}) begin
        errors++;
        $display("FAIL normal_edge%0d: got rst=%h ar=%b busy=%b want rst=%h ar=%b busy=%b",
                 e, dom_rst, all_ready, busy, exp_rst, (e >= 20), (e < 20));
      end
    end
    $display("test_normal_sequence done");
  endtask

  task automatic test_timeout;
    dom_ready = 4'b1011;
    apply_rst();
    for (int e = 1; e <= 274; e++) begin
      tick();
      if (e == 272) begin
        checks++;
        if ({dom_rst, timeout_err, all_ready} !== {4'h8, 4'h0, 1'b0}) begin
          errors++;
          $display("FAIL timeout_before: got rst=%h te=%h ar=%b want rst=8 te=0 ar=0",
                   dom_rst, timeout_err, all_ready);
        end
      end
      if (e == 273) begin
        checks++;
        if ({dom_rst, timeout_err, all_ready, busy} !== {4'h0, 4'h4, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL timeout_expire: got rst=%h te=%h ar=%b busy=%b want rst=0 te=4 ar=0 busy=1",
                   dom_rst, timeout_err, all_ready, busy);
        end
      end
      if (e == 274) begin
        checks++;
        if ({all_ready, busy, timeout_err} !== {1'b1, 1'b0, 4'h4}) begin
          errors++;
          $display("FAIL timeout_run: got ar=%b busy=%b te=%h want ar=1 busy=0 te=4",
                   all_ready, busy, timeout_err);
        end
      end
    end
    // Key restart must not clear the sticky flag.
    dom_ready = 4'hF;
    key       = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == KEY_LAT - 1) begin
        checks++;
        if (dom_rst !== 4'h0) begin
          errors++;
          $display("FAIL timeout_key_early: got rst=%h want rst=0", dom_rst);
        end
      end
      if (e == KEY_LAT) begin
        checks++;
        if ({dom_rst, busy, timeout_err} !== {4'hF, 1'b1, 4'h4}) begin
          errors++;
          $display("FAIL timeout_key_restart: got rst=%h busy=%b te=%h want rst=f busy=1 te=4",
                   dom_rst, busy, timeout_err);
        end
      end
      if (e == 10) key = 1'b0;
    end
    checks++;
    if (timeout_err !== 4'h4) begin
      errors++;
      $display("FAIL timeout_sticky: got te=%h want te=4", timeout_err);
    end
    $display("test_timeout done");
  endtask

  task automatic test_key_restart;
    int r;
    dom_ready = 4'hF;
    key       = 1'b0;
    apply_rst();
    repeat (20) tick();
    checks++;
    if (all_ready !== 1'b1) begin
      errors++;
      $display("FAIL key_pre_run: got ar=%b want ar=1", all_ready);
    end
    key = 1'b1;
    for (int e = 1; e <= KEY_LAT + 21; e++) begin
      tick();
      r = e - KEY_LAT;
      if (e == KEY_LAT - 1) begin
        checks++;
        if ({dom_rst, all_ready} !== {4'h0, 1'b1}) begin
          errors++;
          $display("FAIL key_not_yet: got rst=%h ar=%b want rst=0 ar=1", dom_rst, all_ready);
        end
      end
      if (r == 0 || r == 15 || r == 16 || r == 19 || r == 20) begin
        checks++;
        if ({dom_rst, all_ready, busy} !==
            {((r == 16) ? 4'hE : (r >= 19) ? 4'h0 : 4'hF), (r == 20), (r != 20)}) begin
          errors++;
          $display("FAIL key_seq_r%0d: got rst=%h ar=%b busy=%b want rst=%h ar=%b busy=%b",
                   r, dom_rst, all_ready, busy,
                   ((r == 16) ? 4'hE : (r >= 19) ? 4'h0 : 4'hF), (r == 20), (r != 20));
        end
      end
      if (e == 10) key = 1'b0;
    end
    $display("test_key_restart done");
  endtask

  task automatic test_short_key;
    key = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) begin
        checks++;
        if ({dom_rst, all_ready} !== {SK_RST_E3, SK_AR_E3}) begin
          errors++;
          $display("FAIL short_key_e3: got rst=%h ar=%b want rst=%h ar=%b",
                   dom_rst, all_ready, SK_RST_E3, SK_AR_E3);
        end
      end
      if (e == 12) begin
        checks++;
        if (dom_rst !== SK_RST_E12) begin
          errors++;
          $display("FAIL short_key_e12: got rst=%h want rst=%h", dom_rst, SK_RST_E12);
        end
      end
      if (e == 4) key = 1'b0;
    end
    repeat (25) tick();
    $display("test_short_key done");
  endtask

  task automatic test_rst_mid;
    dom_ready = 4'b1011;
    apply_rst();
    repeat (23) tick();
    checks++;
    if ({dom_rst, busy} !== {4'h8, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_wait: got rst=%h busy=%b want rst=8 busy=1", dom_rst, busy);
    end
    #5;
    rst = 1'b1;
    #1;
    checks++;
    if ({dom_rst, all_ready, busy, timeout_err} !== {4'hF, 1'b0, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL rst_mid_async: got rst=%h ar=%b busy=%b te=%h want rst=f ar=0 busy=1 te=0",
               dom_rst, all_ready, busy, timeout_err);
    end
    dom_ready = 4'hF;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 15 || e == 16) begin
        checks++;
        if (dom_rst !== ((e == 16) ? 4'hE : 4'hF)) begin
          errors++;
          $display("FAIL rst_mid_hold_e%0d: got rst=%h want rst=%h",
                   e, dom_rst, ((e == 16) ? 4'hE : 4'hF));
        end
      end
      if (e == 20) begin
        checks++;
        if (all_ready !== 1'b1) begin
          errors++;
          $display("FAIL rst_mid_run: got ar=%b want ar=1", all_ready);
        end
      end
    end
    $display("test_rst_mid done");
  endtask

  task automatic test_press_at_hold_expiry;
    dom_ready = 4'hF;
    key       = 1'b0;
    apply_rst();
    for (int e = 1; e <= 33; e++) begin
      tick();
      if (e == 16 || e == 31 || e == 32) begin
        checks++;
        if ({dom_rst, busy} !== {((e == 32) ? 4'hE : 4'hF), 1'b1}) begin
          errors++;
          $display("FAIL hold_press_e%0d: got rst=%h busy=%b want rst=%h busy=1",
                   e, dom_rst, busy, ((e == 32) ? 4'hE : 4'hF));
        end
      end
      if (e == 16 - KEY_LAT) key = 1'b1;
      if (e == 24) key = 1'b0;
    end
    $display("test_press_at_hold_expiry done");
  endtask

  initial begin
    test_reset();
    test_normal_sequence();
    test_timeout();
    test_key_restart();
    test_short_key();
    test_rst_mid();
    test_press_at_hold_expiry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
